// File: rtl/clint.sv
// clint - core-local interruptor.
//
// Holds the machine timer (mtime/mtimecmp), the software-interrupt bit (msip)
// and an external-interrupt pending latch, and drives the pending bits that
// are mirrored into mip. Register access is a single-cycle request/ack bus.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   bus_req/we/addr/wdata register request (one per cycle max)
//   bus_ack, bus_rdata    ack one cycle after each request, read data (0 unless ack)
//   ext_irq               asynchronous external interrupt line
//   *_int_clear           level clear requests from the trap controller
//   mip_meip/mtip/msip    registered pending bits
module clint #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [15:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic        bus_ack,
    output logic [31:0] bus_rdata,
    input  logic        ext_irq,
    input  logic        external_int_clear,
    input  logic        software_int_clear,
    input  logic        timer_int_clear,
    output logic        mip_meip,
    output logic        mip_mtip,
    output logic        mip_msip
);

    localparam logic [15:0] ADDR_MSIP      = 16'h0000;
    localparam logic [15:0] ADDR_MTIMECMPL = 16'h4000;
    localparam logic [15:0] ADDR_MTIMECMPH = 16'h4004;
    localparam logic [15:0] ADDR_MTIMEL    = 16'hBFF8;
    localparam logic [15:0] ADDR_MTIMEH    = 16'hBFFC;
    localparam logic [15:0] PRESC_MAX      = 16'(TICK_DIV - 1);

    logic [15:0] presc;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        armed;
    logic        msip;
    logic        sync1, sync2, sync3, edge_q;
    logic        pending;

    logic        wr;
    logic        tick;
    logic        hit;
    logic        cmp_wr;
    logic [31:0] rd_mux;

    assign wr     = bus_req & bus_we;
    assign tick   = (presc == PRESC_MAX);
    assign hit    = (mtime >= mtimecmp);
    assign cmp_wr = wr & ((bus_addr == ADDR_MTIMECMPL) | (bus_addr == ADDR_MTIMECMPH));

    always_comb begin
        rd_mux = '0;
        case (bus_addr)
            ADDR_MSIP:      rd_mux = {31'd0, msip};
            ADDR_MTIMECMPL: rd_mux = mtimecmp[31:0];
            ADDR_MTIMECMPH: rd_mux = mtimecmp[63:32];
            ADDR_MTIMEL:    rd_mux = mtime[31:0];
            ADDR_MTIMEH:    rd_mux = mtime[63:32];
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ack   <= bus_req;
            bus_rdata <= (bus_req && !bus_we) ? rd_mux : '0;
        end
    end

    // Timer: a write to either mtime half replaces that cycle's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            mtime    <= '0;
            mtimecmp <= '1;
            armed    <= 1'b1;
            mip_mtip <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 16'd1;

            if (wr && bus_addr == ADDR_MTIMEL)
                mtime[31:0] <= bus_wdata;
            else if (wr && bus_addr == ADDR_MTIMEH)
                mtime[63:32] <= bus_wdata;
            else if (tick)
                mtime <= mtime + 64'd1;

            if (wr && bus_addr == ADDR_MTIMECMPL)
                mtimecmp[31:0] <= bus_wdata;
            if (wr && bus_addr == ADDR_MTIMECMPH)
                mtimecmp[63:32] <= bus_wdata;

            if (timer_int_clear)
                armed <= 1'b0;
            else if (cmp_wr)
                armed <= 1'b1;

            // Gating with the clear lets mtip fall on the first clear cycle.
            mip_mtip <= hit && armed && !timer_int_clear;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip <= 1'b0;
        end else if (software_int_clear) begin
            msip <= 1'b0;
        end else if (wr && bus_addr == ADDR_MSIP) begin
            msip <= bus_wdata[0];
        end
    end

    assign mip_msip = msip;

    // External: 2-flop synchronizer, registered rising-edge pulse, then latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync3   <= 1'b0;
            edge_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync1  <= ext_irq;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_q <= sync2 & ~sync3;
            if (external_int_clear)
                pending <= 1'b0;
            else if (edge_q)
                pending <= 1'b1;
        end
    end

    assign mip_meip = pending;

endmodule
